// File: rtl/imem_loader.sv
// Writable instruction memory loaded from a big-endian byte stream, with a PC-indexed fetch port.
// Optional trailing checksum byte is enabled by defining IMEM_CHECKSUM_EN.
module imem_loader #(
  parameter int unsigned ADDR_W    = 6,
  parameter logic [31:0] HALT_WORD = 32'hFC000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  input  logic [31:0]       PC,
  output logic [31:0]       instr_out,
  output logic              core_hold,
  output logic              load_done,
  output logic [ADDR_W:0]   word_cnt,
  output logic              checksum_err
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
`ifdef IMEM_CHECKSUM_EN
    CHECK = 2'd2,
`endif
    DONE  = 2'd3
  } state_t;

  state_t        state_q;
  state_t        state_nx;
  logic [31:0]   mem [DEPTH];
  logic [31:0]   asm_q;
  logic [1:0]    byte_idx_q;
  logic          accept_c;
  logic          last_byte_c;
  logic          load_end_c;
  logic [31:0]   word_c;
  logic          unused_pc;

  assign unused_pc   = ^PC[31:ADDR_W];
  assign accept_c    = byte_valid && byte_ready;
  assign word_c      = {asm_q[23:0], byte_data};
  assign last_byte_c = accept_c && (state_q == LOAD) && (byte_idx_q == 2'd3);
  // Load ends on the halt word or when the last memory slot is filled.
  assign load_end_c  = last_byte_c &&
                       ((word_c == HALT_WORD) || (word_cnt == CNT_W'(DEPTH - 1)));

  assign instr_out = (state_q == IDLE) ? mem[PC[ADDR_W-1:0]] : HALT_WORD;

  // State register; handshake/status outputs are registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      byte_ready <= 1'b0;
      core_hold  <= 1'b0;
      load_done  <= 1'b0;
    end else begin
      state_q    <= state_nx;
`ifdef IMEM_CHECKSUM_EN
      byte_ready <= (state_nx == LOAD) || (state_nx == CHECK);
`else
      byte_ready <= (state_nx == LOAD);
`endif
      core_hold  <= (state_nx != IDLE);
      load_done  <= (state_nx == DONE);
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state_q;
    case (state_q)
      IDLE: if (load_start) state_nx = LOAD;
`ifdef IMEM_CHECKSUM_EN
      LOAD:  if (load_end_c) state_nx = CHECK;
      CHECK: if (accept_c)   state_nx = DONE;
`else
      LOAD:  if (load_end_c) state_nx = DONE;
`endif
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Byte assembly and word counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q      <= '0;
      byte_idx_q <= '0;
      word_cnt   <= '0;
    end else if ((state_q == IDLE) && load_start) begin
      asm_q      <= '0;
      byte_idx_q <= '0;
      word_cnt   <= '0;
    end else if ((state_q == LOAD) && accept_c) begin
      asm_q      <= word_c;
      byte_idx_q <= byte_idx_q + 2'd1;
      if (byte_idx_q == 2'd3) word_cnt <= word_cnt + CNT_W'(1);
    end
  end

  // Memory array; reset refills every word with the halt encoding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= HALT_WORD;
    end else if (last_byte_c) begin
      mem[word_cnt[ADDR_W-1:0]] <= word_c;
    end
  end

`ifdef IMEM_CHECKSUM_EN
  logic [7:0] xor_q;

  // Running XOR of the payload, compared against the trailing checksum byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xor_q        <= '0;
      checksum_err <= 1'b0;
    end else if ((state_q == IDLE) && load_start) begin
      xor_q        <= '0;
      checksum_err <= 1'b0;
    end else if ((state_q == LOAD) && accept_c) begin
      xor_q <= xor_q ^ byte_data;
    end else if ((state_q == CHECK) && accept_c && (byte_data != xor_q)) begin
      checksum_err <= 1'b1;
    end
  end
`else
  assign checksum_err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader against a word-level memory model.
// Handles both the default build and IMEM_CHECKSUM_EN.
module tb_imem_loader;

  localparam logic [31:0] HALT = 32'hFC000000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic [31:0] PC;
  logic [31:0] instr_out;
  logic        core_hold;
  logic        load_done;
  logic [6:0]  word_cnt;
  logic        checksum_err;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] model_mem [64];
  logic        model_ckerr;

  imem_loader dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .PC(PC), .instr_out(instr_out), .core_hold(core_hold),
    .load_done(load_done), .word_cnt(word_cnt), .checksum_err(checksum_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < 64; i++) begin
      PC = ($urandom & 32'hFFFF_FFC0) | 32'(i);
      #1;
      check(tag, instr_out, model_mem[i]);
    end
  endtask

  // Offers bytes with optional random gaps and stray load_start pulses.
  task automatic send_bytes(input logic [7:0] q[$], input bit gaps);
    int idx = 0;
    int budget = 0;
    bit fire;
    while (idx < q.size() && budget < 3000) begin
      if (gaps && $urandom_range(0, 3) == 0) byte_valid = 1'b0;
      else begin
        byte_valid = 1'b1;
        byte_data  = q[idx];
      end
      if (gaps && $urandom_range(0, 15) == 0) load_start = 1'b1;
      PC   = $urandom;
      fire = byte_valid && byte_ready;
      tick();
      byte_valid = 1'b0;
      load_start = 1'b0;
      if (fire) idx++;
      budget++;
      if (idx < q.size()) begin
        check("hold_in_load", core_hold, 1);
        check("ready_in_load", byte_ready, 1);
        check("no_early_done", load_done, 0);
        check("fetch_blocked", instr_out, HALT);
      end
    end
    if (budget >= 3000) check("stream_timeout", 64'(idx), 64'(q.size()));
  endtask

  task automatic do_load(input logic [31:0] words[$], input bit gaps, input bit bad_ck);
    logic [7:0] q[$];
    logic [7:0] ck[$];
    logic [7:0] xs = 8'h00;
    int cnt = 0;
    foreach (words[k]) begin
      model_mem[cnt] = words[k];
      cnt++;
      for (int b = 3; b >= 0; b--) begin
        q.push_back(words[k][b*8 +: 8]);
        xs ^= words[k][b*8 +: 8];
      end
      if (words[k] == HALT || cnt == 64) break;
    end
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("ready_on", byte_ready, 1);
    check("hold_on", core_hold, 1);
    check("cnt_cleared", word_cnt, 0);
    check("ckerr_cleared", checksum_err, 0);
    send_bytes(q, gaps);
    model_ckerr = 1'b0;
`ifdef IMEM_CHECKSUM_EN
    check("check_no_done", load_done, 0);
    check("check_ready", byte_ready, 1);
    ck.push_back(bad_ck ? (xs ^ 8'h5A) : xs);
    model_ckerr = bad_ck;
    send_bytes(ck, 1'b0);
`else
    if (bad_ck) ck.push_back(xs);
`endif
    check("done_pulse", load_done, 1);
    check("word_cnt", word_cnt, 64'(cnt));
    check("fetch_in_done", instr_out, HALT);
    tick();
    check("done_one_cycle", load_done, 0);
    check("hold_released", core_hold, 0);
    check("ready_off", byte_ready, 0);
    check("ckerr", checksum_err, model_ckerr);
    sweep("fetch_after_load");
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 64; i++) model_mem[i] = HALT;
    check("rst_ready", byte_ready, 0);
    check("rst_hold", core_hold, 0);
    check("rst_cnt", word_cnt, 0);
    check("rst_ckerr", checksum_err, 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("rst_no_done", load_done, 0);
    end
    rst_n = 1'b1;
    tick();
    check("post_rst_done", load_done, 0);
    check("post_rst_hold", core_hold, 0);
    sweep("fetch_after_reset");
  endtask

  initial begin
    logic [31:0] w[$];
    logic [7:0]  part[$];
    rst_n      = 1'b0;
    load_start = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    PC         = 32'h0;
    for (int i = 0; i < 64; i++) model_mem[i] = HALT;
    #2;
    check("reset_ready", byte_ready, 0);
    check("reset_hold", core_hold, 0);
    check("reset_done", load_done, 0);
    check("reset_cnt", word_cnt, 0);
    check("reset_ckerr", checksum_err, 0);
    tick();
    rst_n = 1'b1;
    tick();
    sweep("fetch_reset");

    w = '{32'h90020028, 32'h00003823, HALT};
    do_load(w, 1'b0, 1'b0);
    do_load(w, 1'b1, 1'b1);

    // Full memory with no halt word; stray load_start pulses during the load.
    w.delete();
    for (int i = 0; i < 64; i++) w.push_back(32'h00003823 + 32'(i));
    do_load(w, 1'b1, 1'b0);

    // Shorter random loads leave the upper words untouched.
    for (int r = 0; r < 6; r++) begin
      logic [31:0] x;
      w.delete();
      for (int i = 0; i < int'($urandom_range(0, 12)); i++) begin
        x = $urandom;
        if (x == HALT) x ^= 32'h1;
        w.push_back(x);
      end
      w.push_back(HALT);
      do_load(w, 1'(r & 1), 1'($urandom_range(0, 1)));
    end

    // Reset after five bytes aborts the load.
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    part = '{8'h90, 8'h02, 8'h00, 8'h28, 8'h11};
    send_bytes(part, 1'b0);
    check("mid_no_done", load_done, 0);
    check("mid_hold", core_hold, 1);
    apply_reset();

    w = '{HALT};
    do_load(w, 1'b0, 1'b0);
    do_load(w, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Writable instruction memory with a byte-stream loader, the write-side counterpart to the instruction fetch/IR path. A host streams big-endian instruction bytes over a valid/ready handshake. The block assembles them into 32-bit words and writes them sequentially from address 0. Fetch logic reads words through a PC-indexed port, and `core_hold` stalls the cores while a load is in progress.

## Interface
- `ADDR_W`, default 6: word address width; depth is 2**ADDR_W words (64).
- `HALT_WORD`, default 32'hFC000000: halt encoding; memory fill value and load terminator.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `load_start` in 1: single-cycle request to begin a load; honoured only in IDLE.
- `byte_valid` in 1: host has a byte on `byte_data`.
- `byte_data` in 8: instruction byte, MSB-first within each word.
- `byte_ready` out 1: block accepts a byte this cycle; a transfer occurs when valid && ready.
- `PC` in 32: fetch address; only `PC[ADDR_W-1:0]` is used.
- `instr_out` out 32: fetched word, combinational from memory.
- `core_hold` out 1: high while not IDLE; cores must stall.
- `load_done` out 1: one-cycle pulse at load completion.
- `word_cnt` out ADDR_W+1: number of words written by the current or last load.
- `checksum_err` out 1: sticky checksum mismatch flag (see Configuration).

## Operation
- States: IDLE, LOAD, CHECK (present only with the macro), DONE.
- IDLE:
  - `byte_ready`=0.
  - `load_start`=1 clears `word_cnt`, the byte index, the assembly register and `checksum_err`, then moves to LOAD.
- LOAD:
  - `byte_ready`=1.
  - Each accepted byte shifts into the assembly register: `asm <= {asm[23:0], byte_data}`.
  - The byte index increments modulo 4.
  - On the 4th byte, `mem[word_cnt]` is written with the assembled word and `word_cnt` increments.
  - Load ends after a write when the written word == `HALT_WORD`, or when `word_cnt` reaches 2**ADDR_W (memory full).
  - At load end the state moves to CHECK if the macro is defined, otherwise to DONE.
- DONE:
  - `load_done`=1 for exactly one cycle, then the state returns to IDLE.
- Fetch port:
  - `instr_out = mem[PC[ADDR_W-1:0]]` in IDLE.
  - `instr_out = HALT_WORD` in every other state, so a stalled core never fetches a partial program.
- Unwritten locations keep their previous contents; a load never clears the upper memory.
- `load_start` outside IDLE is ignored.
- `byte_valid` while `byte_ready`=0 is not consumed; the host must hold the byte.
- Full-memory wrap-around cannot occur: the write address is never ≥ 2**ADDR_W.

## Timing
- Reset values:
  - state IDLE.
  - all memory words = `HALT_WORD`.
  - `byte_ready`=0, `core_hold`=0, `load_done`=0, `word_cnt`=0, `checksum_err`=0.
  - `instr_out` = `HALT_WORD`.
- `load_start` at edge N: `byte_ready` and `core_hold` are high from cycle N+1.
- 4th byte accepted at edge M: the memory write and `word_cnt` update happen at edge M. If this ends the load, the state at M+1 is DONE (or CHECK), and `load_done` is high during cycle M+1.
- Back-to-back bytes are accepted every cycle; maximum throughput is 1 byte/clk.
- A new word is readable on `instr_out` the first IDLE cycle after DONE.
- Reset mid-load aborts immediately: memory returns to all-`HALT_WORD`, no `load_done` is issued, and `word_cnt`=0.

## Configuration
- Macro `IMEM_CHECKSUM_EN`, defined:
  - An 8-bit XOR of all bytes accepted in LOAD is accumulated.
  - After load end the block enters CHECK with `byte_ready`=1 and accepts exactly one checksum byte.
  - If that byte != accumulated XOR, `checksum_err` is set. It stays set until the next `load_start` or reset.
  - The state then moves to DONE.
  - Memory contents are kept either way.
- Macro not defined:
  - No CHECK state and no extra byte.
  - `checksum_err` tied to 0.

## Test plan
- Reset then `PC`=0..63 -> `instr_out`=32'hFC000000 everywhere; `core_hold`=0, `word_cnt`=0.
- Load bytes 90 02 00 28 / 00 00 38 23 / FC 00 00 00 back-to-back -> `load_done` pulse one cycle after the 12th byte, `word_cnt`=3, then `mem[0]`=90020028, `mem[1]`=00003823, `mem[2]`=FC000000.
- Same stream with `byte_valid` dropped for 3 cycles mid-word -> identical memory, `load_done` delayed by 3 cycles; `instr_out`=FC000000 throughout the load.
- Stream 64 non-halt words (e.g. 00003823) -> ends on word 64 with `word_cnt`=64, `load_done`=1; `load_start` pulsed during LOAD is ignored.
- Assert `rst_n`=0 after 5 bytes -> immediate IDLE, `byte_ready`=0, all words FC000000, no `load_done`.
- With `IMEM_CHECKSUM_EN` defined: halt-only stream FC 00 00 00 then checksum FC -> `checksum_err`=0; repeat with checksum 00 -> `checksum_err`=1, `load_done` still pulses.
